// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Central sequencer for the fetch PC and its branch predictor. Every cycle it
// chooses whether the PC follows the predicted path, holds, or loads a
// redirect address, and raises the matching stall/flush controls.
// Redirect sources are:
//   - branch mispredict
//   - interrupt entry (through a one-cycle TAKE state that loads the vector)
//   - return-from-interrupt (ERET)
//   - halt
// It also owns the EPC register and the served-interrupt id.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   halt_i            halt syscall resolved in EX
//   load_use_i        load-use hazard detected in ID
//   mispred_i         EX branch disagrees with prediction
//   mispred_target_i  correct next PC for the mispredicted branch
//   ex_valid_i        EX holds a real (non-bubble) instruction
//   ex_pc_i           PC of the EX instruction
//   eret_i            ERET resolved in EX
//   irq_i             level-sensitive interrupt requests (index 0 highest)
//   irq_en_i          per-line interrupt enable mask
//   pc_en_o           PC register load enable           (combinational)
//   pc_sel_o          0 = predicted PC, 1 = redirect    (combinational)
//   redirect_addr_o   redirect target                   (combinational)
//   stall_o           hold IF/ID                        (combinational)
//   flush_if_id_o     squash IF/ID                      (combinational)
//   flush_id_ex_o     bubble into ID/EX                 (combinational)
//   flush_ex_o        squash the EX instruction         (combinational)
//   epc_o             saved return PC                   (registered)
//   in_isr_o          handler executing                 (registered)
//   irq_ack_o         one-hot pulse on handler return   (registered)
//   halted_o          core halted                       (registered)
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int                ADDR_W     = 10,
    parameter int                IRQ_N      = 3,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 'h3C0,
    parameter int                VEC_STRIDE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt_i,
    input  logic              load_use_i,
    input  logic              mispred_i,
    input  logic [ADDR_W-1:0] mispred_target_i,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              eret_i,
    input  logic [IRQ_N-1:0]  irq_i,
    input  logic [IRQ_N-1:0]  irq_en_i,
    output logic              pc_en_o,
    output logic              pc_sel_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              stall_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              flush_ex_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              in_isr_o,
    output logic [IRQ_N-1:0]  irq_ack_o,
    output logic              halted_o
);

    localparam int ID_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_TAKE,
        S_ISR,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_epc;
    logic [ID_W-1:0]   r_id;
    logic              r_in_isr;
    logic [IRQ_N-1:0]  r_irq_ack;
    logic              r_halted;

    logic [IRQ_N-1:0]  w_pending;
    logic [ID_W-1:0]   w_pend_id;
    logic              w_take;
    logic              w_eret;
    logic [ADDR_W-1:0] w_vec_addr;

    assign w_pending = irq_i & irq_en_i;

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_pend_id = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_pend_id = ID_W'(i);
            end
        end
    end

    // Interrupt entry waits for a real EX instruction so EPC never names a bubble.
    assign w_take = (r_state == S_RUN) && !halt_i && !mispred_i &&
                    (|w_pending) && ex_valid_i;

    // A same-cycle mispredict means the ERET is on a squashed path; drop it.
    assign w_eret = (r_state == S_ISR) && !halt_i && !mispred_i && eret_i;

    assign w_vec_addr = VEC_BASE + ADDR_W'(int'(r_id) * VEC_STRIDE);

    always_comb begin
        pc_en_o         = 1'b1;
        pc_sel_o        = 1'b0;
        redirect_addr_o = '0;
        stall_o         = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        flush_ex_o      = 1'b0;
        case (r_state)
            S_HALT: begin
                pc_en_o = 1'b0;
            end
            S_TAKE: begin
                // Vector load; mispredict and load-use are meaningless here
                // because the younger stages were all squashed on entry.
                pc_sel_o        = 1'b1;
                redirect_addr_o = w_vec_addr;
                flush_if_id_o   = 1'b1;
                flush_id_ex_o   = 1'b1;
            end
            default: begin
                if (halt_i) begin
                    pc_en_o       = 1'b0;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (mispred_i) begin
                    pc_sel_o        = 1'b1;
                    redirect_addr_o = mispred_target_i;
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                end else if (w_eret) begin
                    pc_sel_o        = 1'b1;
                    redirect_addr_o = r_epc;
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                end else if (w_take) begin
                    // The EX instruction becomes the return point, so it must
                    // not retire now; everything younger is squashed too.
                    pc_en_o       = 1'b0;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    flush_ex_o    = 1'b1;
                end else if (load_use_i) begin
                    pc_en_o       = 1'b0;
                    stall_o       = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_epc     <= '0;
            r_id      <= '0;
            r_in_isr  <= 1'b0;
            r_irq_ack <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_irq_ack <= '0;
            case (r_state)
                S_RUN: begin
                    if (halt_i) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_take) begin
                        r_state <= S_TAKE;
                        r_epc   <= ex_pc_i;
                        r_id    <= w_pend_id;
                    end
                end
                S_TAKE: begin
                    r_state  <= S_ISR;
                    r_in_isr <= 1'b1;
                end
                S_ISR: begin
                    if (halt_i) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_eret) begin
                        r_state   <= S_RUN;
                        r_in_isr  <= 1'b0;
                        r_irq_ack <= IRQ_N'(1) << r_id;
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign epc_o     = r_epc;
    assign in_isr_o  = r_in_isr;
    assign irq_ack_o = r_irq_ack;
    assign halted_o  = r_halted;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Central sequencer for the fetch PC register and its branch predictor.
- Each cycle it decides whether the PC advances along the predicted path, holds, or loads a redirect address. Redirect sources: branch mispredict, interrupt entry, return-from-interrupt, halt.
- Drives PC enable/select and the matching pipeline flush/stall signals, owns the EPC register, and arbitrates among prioritized interrupt lines.

Parameters:
- ADDR_W, 10: instruction-memory word-address width; same width as the fetch PC.
- IRQ_N, 3: number of interrupt request lines; index 0 has the highest priority.
- VEC_BASE, 10'h3C0: word address of the interrupt-0 handler.
- VEC_STRIDE, 16: word spacing between handler entry points.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- halt_i  in  1  halt syscall resolved in EX
- load_use_i  in  1  load-use hazard detected in ID
- mispred_i  in  1  EX branch outcome/target disagrees with prediction
- mispred_target_i  in  ADDR_W  correct next PC for the mispredicted branch
- ex_valid_i  in  1  EX holds a real (non-bubble) instruction
- ex_pc_i  in  ADDR_W  PC of the EX instruction
- eret_i  in  1  ERET resolved in EX
- irq_i  in  IRQ_N  level-sensitive interrupt requests
- irq_en_i  in  IRQ_N  per-line interrupt enable mask
- pc_en_o  out  1  PC register load enable
- pc_sel_o  out  1  0 = predicted next PC, 1 = redirect_addr_o
- redirect_addr_o  out  ADDR_W  redirect target
- stall_o  out  1  hold IF/ID
- flush_if_id_o  out  1  squash IF/ID
- flush_id_ex_o  out  1  insert bubble into ID/EX
- flush_ex_o  out  1  squash the EX instruction (no writeback, no memory write)
- epc_o  out  ADDR_W  saved return PC (registered)
- in_isr_o  out  1  handler executing (registered)
- irq_ack_o  out  IRQ_N  one-hot, one-cycle pulse when the served line's handler returns (registered)
- halted_o  out  1  core halted (registered)

Behaviour:
- States: RUN, TAKE, ISR, HALT. Reset state RUN.
- Reset values: epc_o = 0, in_isr_o = 0, irq_ack_o = 0, halted_o = 0, served-id register = 0.
- All control outputs are combinational from state and inputs. A redirect asserts pc_en_o = 1 and pc_sel_o = 1 in the same cycle, so the PC holds the target after the next rising edge (latency 1).
- Default when no event applies: pc_en_o = 1, pc_sel_o = 0, all flush/stall signals 0.
- Per-cycle priority in RUN/ISR, highest first: halt_i > mispred_i > eret_i (ISR only) > interrupt take (RUN only) > load_use_i.
- halt_i: next state HALT; pc_en_o = 0; flush_if_id_o = 1, flush_id_ex_o = 1.
  - In HALT: pc_en_o = 0, halted_o = 1, all other inputs ignored. Only reset exits.
- mispred_i: redirect_addr_o = mispred_target_i; flush_if_id_o = 1, flush_id_ex_o = 1; state unchanged.
- Interrupt take, RUN only. Condition: pending = irq_i & irq_en_i is non-zero, ex_valid_i = 1, and no halt or mispredict this cycle.
  - Captured on the edge: epc = ex_pc_i; served id = lowest set index of pending.
  - Same cycle: flush_ex_o = 1, flush_id_ex_o = 1, flush_if_id_o = 1, pc_en_o = 0. Next state TAKE.
  - If ex_valid_i = 0, the take is deferred until EX holds a real instruction, so EPC always names a real instruction.
- TAKE (exactly one cycle): pc_en_o = 1, pc_sel_o = 1, redirect_addr_o = VEC_BASE + id*VEC_STRIDE (truncated to ADDR_W); flush_if_id_o = 1, flush_id_ex_o = 1. mispred_i and load_use_i are ignored. Next state ISR; in_isr_o becomes 1.
- ISR: no nesting; irq_i is ignored.
  - eret_i: redirect_addr_o = epc_o; flush_if_id_o = 1, flush_id_ex_o = 1; next RUN. in_isr_o clears and irq_ack_o[id] pulses on the same edge.
- load_use_i (lowest priority): pc_en_o = 0, stall_o = 1, flush_id_ex_o = 1.
- Mispredict and ERET in the same ISR cycle: mispredict wins, ERET is dropped. The ERET sits on a squashed path by construction.
- Asynchronous reset asserted mid-TAKE/ISR/HALT: immediate return to RUN with reset values. No pending interrupt is remembered; the level-sensitive line re-requests.

Test Plan:
- Reset, no events for 4 cycles -> pc_en_o = 1, pc_sel_o = 0 every cycle; epc_o = 0, in_isr_o = 0, halted_o = 0.
- mispred_i = 1, mispred_target_i = 10'h05A for one cycle -> same cycle pc_sel_o = 1, redirect_addr_o = 10'h05A, flush_if_id_o = 1 and flush_id_ex_o = 1; state stays RUN.
- irq_i = 3'b110, irq_en_i = 3'b111, ex_valid_i = 1, ex_pc_i = 10'h020 -> take cycle flushes all stages with pc_en_o = 0; next cycle redirect_addr_o = 10'h3D0 (id 1); then in_isr_o = 1, epc_o = 10'h020.
- In ISR, assert eret_i -> redirect_addr_o = 10'h020; next cycle in_isr_o = 0 and irq_ack_o = 3'b010 for exactly one cycle.
- irq_i = 3'b001 together with mispred_i = 1 -> mispredict redirect only; interrupt taken on the following cycle with epc = the ex_pc_i of that cycle.
- halt_i = 1 -> pc_en_o = 0 permanently and halted_o = 1; mispred_i/irq_i ignored; rst_n low for 1 ns -> state RUN, halted_o = 0.
